// File: rtl/sao_stat_pkg.sv
// SAO statistics accumulator: shared state type, width defaults
// and the saturating adders used by every lane.
package sao_stat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_e;

  localparam int SUM_BIT_DEF = 18;
  localparam int CNT_BIT_DEF = 13;

  // Result is clamped to a w-bit signed range, w <= 32.
  function automatic logic signed [31:0] sat_add_s(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] mx;
    logic signed [32:0] mn;
    s  = 33'(a) + 33'(b);
    mx = (33'sd1 <<< (w - 1)) - 33'sd1;
    mn = -(33'sd1 <<< (w - 1));
    if (s > mx) begin
      s = mx;
    end else if (s < mn) begin
      s = mn;
    end
    return s[31:0];
  endfunction

  // Result is clamped to a w-bit unsigned range, w < 32.
  function automatic logic [31:0] sat_add_u(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) begin
      s = mx;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/sao_stat_accum_if.sv
// Drain-side bus of the SAO statistics accumulator:
// one category total per handshake.
interface sao_stat_accum_if
  import sao_stat_pkg::*;
#(
  parameter int N_CATE  = 4,
  parameter int SUM_BIT = SUM_BIT_DEF,
  parameter int CNT_BIT = CNT_BIT_DEF
);
  localparam int IDX_W = (N_CATE > 1) ? $clog2(N_CATE) : 1;

  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_W-1:0]          out_idx;
  logic signed [SUM_BIT-1:0] out_sum;
  logic [CNT_BIT-1:0]        out_cnt;

  modport master (
    output out_valid,
    output out_idx,
    output out_sum,
    output out_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_sum,
    input  out_cnt,
    output out_ready
  );
endinterface

// File: rtl/sao_stat_acc_lane.sv
// One category lane: saturating diff-sum and pixel-count pair
// with clear, clear-and-load and accumulate.
module sao_stat_acc_lane
  import sao_stat_pkg::*;
#(
  parameter int S31_W   = 7,
  parameter int SUM_BIT = SUM_BIT_DEF,
  parameter int CNT_BIT = CNT_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      clr,
  input  logic                      add_en,
  input  logic signed [S31_W-1:0]   s31_i,
  input  logic [1:0]                cnt_i,
  output logic signed [SUM_BIT-1:0] sum_o,
  output logic [CNT_BIT-1:0]        cnt_o
);

  logic signed [SUM_BIT-1:0] sum_q, sum_d, sum_base;
  logic [CNT_BIT-1:0]        cnt_q, cnt_d, cnt_base;
  logic signed [31:0]        inc_s;
  logic [31:0]               inc_c;

  // Clear-and-load is a clear followed by an ordinary add.
  always_comb begin
    sum_base = clr ? '0 : sum_q;
    cnt_base = clr ? '0 : cnt_q;
    inc_s    = '0;
    inc_c    = '0;
    if (add_en) begin
      inc_s = 32'(s31_i);
      inc_c = 32'(cnt_i);
    end
    sum_d = SUM_BIT'(sat_add_s(32'(sum_base), inc_s, SUM_BIT));
    cnt_d = CNT_BIT'(sat_add_u(32'(cnt_base), inc_c, CNT_BIT));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o = sum_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/sao_stat_accum.sv
// Per-CTB SAO statistics accumulator: control FSM, lanes,
// and the registered drain mux toward offset estimation.
module sao_stat_accum
  import sao_stat_pkg::*;
#(
  parameter int PIX3          = 3,
  parameter int diff_clip_bit = 4,
  parameter int N_CATE        = 4,
  parameter int SUM_BIT       = SUM_BIT_DEF,
  parameter int CNT_BIT       = CNT_BIT_DEF
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          ctb_start,
  input  logic                          in_valid,
  input  logic signed [diff_clip_bit+2:0] s31 [N_CATE],
  input  logic [1:0]                    cnt_in [N_CATE],
  input  logic                          ctb_end,
  sao_stat_accum_if.master              drn,
  output logic                          busy
);

  localparam int S31_W = diff_clip_bit + 3;
  localparam int IDX_W = (N_CATE > 1) ? $clog2(N_CATE) : 1;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             clr, add_en;

  logic signed [SUM_BIT-1:0] sum_w [N_CATE];
  logic [CNT_BIT-1:0]        cnt_w [N_CATE];

  for (genvar k = 0; k < N_CATE; k++) begin : g_lane
    sao_stat_acc_lane #(
      .S31_W  (S31_W),
      .SUM_BIT(SUM_BIT),
      .CNT_BIT(CNT_BIT)
    ) u_lane (
      .clk   (clk),
      .arst_n(arst_n),
      .clr   (clr),
      .add_en(add_en),
      .s31_i (s31[k]),
      .cnt_i (cnt_in[k]),
      .sum_o (sum_w[k]),
      .cnt_o (cnt_w[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    clr         = 1'b0;
    add_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctb_start) begin
          clr     = 1'b1;
          add_en  = in_valid;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        add_en = in_valid;
        if (ctb_start) begin
          clr = 1'b1;
        end else if (ctb_end) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
        end
      end
      DRAIN: begin
        if (out_valid_q && drn.out_ready) begin
          if (out_idx_q == IDX_W'(N_CATE - 1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
          end else begin
            out_idx_d = out_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy          = busy_q;
  assign drn.out_valid = out_valid_q;
  assign drn.out_idx   = out_idx_q;
  assign drn.out_sum   = sum_w[out_idx_q];
  assign drn.out_cnt   = cnt_w[out_idx_q];

  for (genvar k = 0; k < N_CATE; k++) begin : g_chk
    a_cnt_in: assert property (
      @(posedge clk) disable iff (!arst_n)
      in_valid |-> 32'(cnt_in[k]) <= PIX3
    );
  end

  a_end_state: assert property (
    @(posedge clk) disable iff (!arst_n)
    ctb_end |-> state_q == ACCUM
  );

  a_hold: assert property (
    @(posedge clk) disable iff (!arst_n)
    (drn.out_valid && !drn.out_ready) |=>
      ($stable(drn.out_sum) && $stable(drn.out_cnt))
  );

endmodule

// File: tb/tb_sao_stat_accum.sv
// Directed bench for sao_stat_accum with queue scoreboards
// and negedge drain monitors on two parameterisations.
module tb_sao_stat_accum;
  import sao_stat_pkg::*;

  typedef struct {
    int idx;
    int sum;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  int vec_n = 0;
  int err_n = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic start_a = 1'b0, vld_a = 1'b0, end_a = 1'b0, busy_a;
  logic signed [6:0] s_a [4];
  logic [1:0]        c_a [4];
  logic start_b = 1'b0, vld_b = 1'b0, end_b = 1'b0, busy_b;
  logic signed [6:0] s_b [4];
  logic [1:0]        c_b [4];

  sao_stat_accum_if #(.N_CATE(4), .SUM_BIT(18), .CNT_BIT(13)) ifa ();
  sao_stat_accum_if #(.N_CATE(4), .SUM_BIT(8), .CNT_BIT(4)) ifb ();

  sao_stat_accum #(.N_CATE(4), .SUM_BIT(18), .CNT_BIT(13)) dut_a (
    .clk      (clk),
    .arst_n   (arst_n),
    .ctb_start(start_a),
    .in_valid (vld_a),
    .s31      (s_a),
    .cnt_in   (c_a),
    .ctb_end  (end_a),
    .drn      (ifa),
    .busy     (busy_a)
  );

  sao_stat_accum #(.N_CATE(4), .SUM_BIT(8), .CNT_BIT(4)) dut_b (
    .clk      (clk),
    .arst_n   (arst_n),
    .ctb_start(start_b),
    .in_valid (vld_b),
    .s31      (s_b),
    .cnt_in   (c_b),
    .ctb_end  (end_b),
    .drn      (ifb),
    .busy     (busy_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vec_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int v0, v1, v2, v3, k0, k1, k2, k3);
    s_a[0] = 7'(v0); s_a[1] = 7'(v1); s_a[2] = 7'(v2); s_a[3] = 7'(v3);
    c_a[0] = 2'(k0); c_a[1] = 2'(k1); c_a[2] = 2'(k2); c_a[3] = 2'(k3);
  endtask

  task automatic set_b(input int v0, v1, v2, v3, k0, k1, k2, k3);
    s_b[0] = 7'(v0); s_b[1] = 7'(v1); s_b[2] = 7'(v2); s_b[3] = 7'(v3);
    c_b[0] = 2'(k0); c_b[1] = 2'(k1); c_b[2] = 2'(k2); c_b[3] = 2'(k3);
  endtask

  task automatic push_a(input int s0, s1, s2, s3, k0, k1, k2, k3);
    qa.push_back('{0, s0, k0});
    qa.push_back('{1, s1, k1});
    qa.push_back('{2, s2, k2});
    qa.push_back('{3, s3, k3});
  endtask

  task automatic push_b(input int s0, s1, s2, s3, k0, k1, k2, k3);
    qb.push_back('{0, s0, k0});
    qb.push_back('{1, s1, k1});
    qb.push_back('{2, s2, k2});
    qb.push_back('{3, s3, k3});
  endtask

  task automatic wait_idle_a(input string nm);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      tick();
      n++;
    end
    chk(nm, int'(busy_a), 0);
  endtask

  task automatic wait_idle_b(input string nm);
    int n;
    n = 0;
    while (busy_b && n < 40) begin
      tick();
      n++;
    end
    chk(nm, int'(busy_b), 0);
  endtask

  always @(negedge clk) begin
    if (arst_n && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        vec_n++;
        err_n++;
        $display("FAIL a_extra: got idx %0d expected none", ifa.out_idx);
      end else begin
        ea = qa.pop_front();
        chk("a_idx", int'(ifa.out_idx), ea.idx);
        chk("a_sum", int'(ifa.out_sum), ea.sum);
        chk("a_cnt", int'(ifa.out_cnt), ea.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (arst_n && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        vec_n++;
        err_n++;
        $display("FAIL b_extra: got idx %0d expected none", ifb.out_idx);
      end else begin
        eb = qb.pop_front();
        chk("b_idx", int'(ifb.out_idx), eb.idx);
        chk("b_sum", int'(ifb.out_sum), eb.sum);
        chk("b_cnt", int'(ifb.out_cnt), eb.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b1;
    #12 arst_n = 1'b1;
    tick();
    chk("rst_valid", int'(ifa.out_valid), 0);
    chk("rst_idx", int'(ifa.out_idx), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_sum", int'(ifa.out_sum), 0);
    chk("rst_cnt", int'(ifa.out_cnt), 0);

    // in_valid without ctb_start in IDLE
    set_a(9, 9, 9, 9, 3, 3, 3, 3);
    vld_a = 1'b1;
    tick();
    tick();
    vld_a = 1'b0;
    chk("idle_busy", int'(busy_a), 0);
    chk("idle_valid", int'(ifa.out_valid), 0);

    // basic accumulation plus backpressure at idx1
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("acc_busy", int'(busy_a), 1);
    set_a(5, -3, 0, 45, 3, 1, 0, 3);
    vld_a = 1'b1;
    tick();
    tick();
    tick();
    end_a = 1'b1;
    push_a(20, -12, 0, 180, 12, 4, 0, 12);
    chk("pre_valid", int'(ifa.out_valid), 0);
    tick();
    vld_a = 1'b0;
    end_a = 1'b0;
    chk("lat_valid", int'(ifa.out_valid), 1);
    chk("lat_idx", int'(ifa.out_idx), 0);
    chk("drain_busy", int'(busy_a), 1);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    set_a(9, 9, 9, 9, 3, 3, 3, 3);
    vld_a = 1'b1;
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_idx", int'(ifa.out_idx), 1);
      chk("bp_sum", int'(ifa.out_sum), -12);
      chk("bp_cnt", int'(ifa.out_cnt), 4);
      tick();
    end
    vld_a = 1'b0;
    start_a = 1'b0;
    chk("bp_idx_end", int'(ifa.out_idx), 1);
    chk("bp_sum_end", int'(ifa.out_sum), -12);
    ifa.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("end_valid", int'(ifa.out_valid), 0);
    chk("end_busy", int'(busy_a), 0);
    chk("end_idx", int'(ifa.out_idx), 0);
    chk("qa_empty1", qa.size(), 0);

    // saturation with SUM_BIT=8, CNT_BIT=4
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    set_b(45, -50, 0, 1, 3, 0, 0, 1);
    vld_b = 1'b1;
    tick();
    tick();
    end_b = 1'b1;
    push_b(127, -128, 0, 3, 9, 0, 0, 3);
    tick();
    vld_b = 1'b0;
    end_b = 1'b0;
    wait_idle_b("sat1_idle");
    start_b = 1'b1;
    vld_b = 1'b1;
    set_b(45, -50, 0, 1, 3, 0, 0, 1);
    tick();
    start_b = 1'b0;
    tick();
    tick();
    set_b(-48, 50, 0, 1, 3, 0, 0, 1);
    tick();
    tick();
    end_b = 1'b1;
    push_b(-17, 22, 0, 6, 15, 0, 0, 6);
    tick();
    vld_b = 1'b0;
    end_b = 1'b0;
    wait_idle_b("sat2_idle");
    chk("qb_empty", qb.size(), 0);

    // restart mid-ACCUM, with ctb_end in the same cycle
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    set_a(10, 2, -4, 1, 1, 1, 1, 1);
    vld_a = 1'b1;
    tick();
    tick();
    tick();
    set_a(7, -1, 3, 0, 2, 0, 3, 1);
    start_a = 1'b1;
    end_a = 1'b1;
    tick();
    start_a = 1'b0;
    end_a = 1'b0;
    vld_a = 1'b0;
    chk("rs_valid", int'(ifa.out_valid), 0);
    chk("rs_busy", int'(busy_a), 1);
    push_a(7, -1, 3, 0, 2, 0, 3, 1);
    end_a = 1'b1;
    tick();
    end_a = 1'b0;
    wait_idle_a("rs_idle");
    chk("qa_empty2", qa.size(), 0);

    // asynchronous reset in the middle of a drain
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    set_a(1, 2, 3, 4, 1, 1, 1, 1);
    vld_a = 1'b1;
    end_a = 1'b1;
    qa.push_back('{0, 1, 1});
    qa.push_back('{1, 2, 1});
    tick();
    vld_a = 1'b0;
    end_a = 1'b0;
    tick();
    tick();
    ifa.out_ready = 1'b0;
    chk("ar_idx2", int'(ifa.out_idx), 2);
    #2 arst_n = 1'b0;
    #1;
    chk("ar_valid", int'(ifa.out_valid), 0);
    chk("ar_busy", int'(busy_a), 0);
    chk("ar_idx", int'(ifa.out_idx), 0);
    chk("ar_sum", int'(ifa.out_sum), 0);
    chk("ar_cnt", int'(ifa.out_cnt), 0);
    tick();
    tick();
    arst_n = 1'b1;
    chk("qa_empty3", qa.size(), 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    end_a = 1'b1;
    push_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    end_a = 1'b0;
    ifa.out_ready = 1'b1;
    wait_idle_a("ar_idle");
    chk("qa_empty4", qa.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
